up_down_counter: RTL and testbench

UP_DOWN_COUNTER -- requirements
Module: up_down_counter

---
 rtl/up_down_counter.sv | 58 +++++
 tb/tb_up_down_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/up_down_counter.sv
// ============================================================================
// Module      : up_down_counter
// Description : WIDTH-bit up/down counter with enable and synchronous parallel
//               load, plus an optional terminal-count flag (macro UDC_TC_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] Din,
`ifdef UDC_TC_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] Qout
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Load takes precedence over counting; en gates both at the register.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = Din;
    end else if (mode) begin
      w_next = r_count - c_one;
    end else begin
      w_next = r_count + c_one;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_next;
    end
  end

  assign Qout = r_count;

`ifdef UDC_TC_EN
  // Flags the edge on which a count would wrap; masked while reset holds Qout=0.
  assign tc = ~reset & en & ~load & (mode ? (r_count == '0) : (&r_count));
`endif

endmodule

`default_nettype wire

// File: tb/tb_up_down_counter.sv
// ============================================================================
// Module      : tb_up_down_counter
// Description : Directed, table-driven bench for up_down_counter (WIDTH=4);
//               tc checks are compiled in when UDC_TC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic       mode;
  logic [3:0] Din;
  logic [3:0] Qout;
`ifdef UDC_TC_EN
  logic       tc;
`endif

  up_down_counter #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .load (load),
    .mode (mode),
    .Din  (Din),
`ifdef UDC_TC_EN
    .tc   (tc),
`endif
    .Qout (Qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic       md;
    logic [3:0] din;
    logic [3:0] q;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic r, input logic e, input logic l, input logic m,
                     input logic [3:0] d, input logic [3:0] q);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.md = m; v.din = d; v.q = q;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input logic m,
                      input logic [3:0] d);
    @(negedge clk);
    reset = r; en = e; load = l; mode = m; Din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; Din = 4'h0;
    #1;
    check("reset_state", Qout, 4'h0);

    // Up count through the wrap: 1..15, 0..4
    add(1, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 1; i <= 20; i++) add(0, 1, 0, 0, 4'h0, 4'(i % 16));
    // Down count through the wrap: 15..1, 0, 15..12
    add(1, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 1; i <= 20; i++) add(0, 1, 0, 1, 4'h0, 4'((16 - i) % 16));
    // Load 0xF in down mode, then 5 down edges
    add(0, 1, 1, 1, 4'hF, 4'hF);
    add(0, 1, 0, 1, 4'h0, 4'hE);
    add(0, 1, 0, 1, 4'h0, 4'hD);
    add(0, 1, 0, 1, 4'h0, 4'hC);
    add(0, 1, 0, 1, 4'h0, 4'hB);
    add(0, 1, 0, 1, 4'h0, 4'hA);
    // Load 0x1 in up mode, then 5 up edges
    add(0, 1, 1, 0, 4'h1, 4'h1);
    add(0, 1, 0, 0, 4'h0, 4'h2);
    add(0, 1, 0, 0, 4'h0, 4'h3);
    add(0, 1, 0, 0, 4'h0, 4'h4);
    add(0, 1, 0, 0, 4'h0, 4'h5);
    add(0, 1, 0, 0, 4'h0, 4'h6);
    // Enable gating: load pulse and mode toggles ignored
    add(0, 0, 1, 0, 4'hC, 4'h6);
    add(0, 0, 0, 1, 4'hC, 4'h6);
    add(0, 0, 0, 0, 4'hC, 4'h6);
    add(0, 0, 1, 1, 4'hC, 4'h6);
    add(0, 0, 0, 0, 4'hC, 4'h6);
    add(0, 0, 0, 1, 4'hC, 4'h6);
    // Load plus direction change in the same cycle, then count down
    add(0, 1, 1, 1, 4'h3, 4'h3);
    add(0, 1, 0, 1, 4'h0, 4'h2);
    // Direction flips with no skipped value
    add(0, 1, 0, 0, 4'h0, 4'h3);
    add(0, 1, 0, 1, 4'h0, 4'h2);
    add(0, 1, 0, 0, 4'h0, 4'h3);
    // Reset dominates everything, then first down edge gives 15
    add(1, 1, 1, 0, 4'h9, 4'h0);
    add(1, 1, 0, 0, 4'h9, 4'h0);
    add(0, 1, 0, 1, 4'h0, 4'hF);
    add(0, 1, 0, 1, 4'h0, 4'hE);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].md, tbl[i].din);
      check($sformatf("vec%0d", i), Qout, tbl[i].q);
    end

    // Asynchronous reset between edges while Qout=7
    step(0, 1, 1, 0, 4'h7);
    check("async_pre", Qout, 4'h7);
    @(negedge clk);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_immediate", Qout, 4'h0);
    @(posedge clk);
    #1;
    check("async_held", Qout, 4'h0);
    step(0, 1, 0, 0, 4'h0);
    check("async_resume_up", Qout, 4'h1);

`ifdef UDC_TC_EN
    step(0, 1, 1, 0, 4'hF);
    check("tc_load_f", Qout, 4'hF);
    @(negedge clk);
    en = 1'b1; load = 1'b0; mode = 1'b0;
    #1 check("tc_up_at_max", {3'b0, tc}, 4'h1);
    load = 1'b1;
    #1 check("tc_masked_by_load", {3'b0, tc}, 4'h0);
    load = 1'b0; en = 1'b0;
    #1 check("tc_masked_by_en", {3'b0, tc}, 4'h0);
    en = 1'b1; mode = 1'b1;
    #1 check("tc_down_at_max", {3'b0, tc}, 4'h0);
    step(0, 1, 1, 1, 4'h0);
    check("tc_load_0", Qout, 4'h0);
    @(negedge clk);
    load = 1'b0; mode = 1'b1; en = 1'b1;
    #1 check("tc_down_at_zero", {3'b0, tc}, 4'h1);
    mode = 1'b0;
    #1 check("tc_up_at_zero", {3'b0, tc}, 4'h0);
    mode = 1'b1; reset = 1'b1;
    #1 check("tc_in_reset", {3'b0, tc}, 4'h0);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
